spi_xfer_ctrl: RTL

Transaction sequencer for the SPI master baud-rate generator. It accepts a word-transfer request, latches and drives the generator's mode and rate configuration, and gates its strobe and SCLK enables. It owns slave select, shifts MOSI out and MISO in on the generator's rise/fall pulses, and returns the received word with a one-cycle done pulse. It sits between the host register interface and the baud-rate generator inside the SPI master.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_shift_unit.sv | 88 ++++++++
 rtl/spi_xfer_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   - FSM state encodings for spi_xfer_ctrl
//   - bit positions of cpol/cpha inside the 2-bit mode word
//   - default word width and setup/hold strobe count
package spi_pkg;

    localparam int unsigned DATA_W_DEF        = 8;
    localparam int unsigned SETUP_STROBES_DEF = 1;

    // Bit positions inside mode = {cpol, cpha}
    localparam int unsigned CPOL = 1;
    localparam int unsigned CPHA = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_shift_unit.sv
// TX/RX shift registers for one SPI word, with capture/change decode.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   load                   start of transfer: latch tx_data and bit order
//   tx_data, lsb_first     word to send and its bit order
//   cpha                   latched clock phase
//   active                 high while SCLK edges are being produced
//   first_edge, last_edge  current edge is the first / last of the word
//   rise, fall             generator leading / trailing edge pulses
//   miso                   serial input
//   mosi                   serial output (registered)
//   rx_word                receive shift register contents
module spi_shift_unit
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              lsb_first,
    input  logic              cpha,
    input  logic              active,
    input  logic              first_edge,
    input  logic              last_edge,
    input  logic              rise,
    input  logic              fall,
    input  logic              miso,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_word
);

    logic [DATA_W-1:0] tx_shreg;
    logic              lsb_q;
    logic              capture;
    logic              change;

    // cpha=0: sample on leading, shift on trailing (the last trailing edge has
    // no next bit). cpha=1: the first bit is already on mosi before the first
    // leading edge, so that edge does not shift.
    always_comb begin
        capture = 1'b0;
        change  = 1'b0;
        if (active) begin
            if (cpha) begin
                capture = fall;
                change  = rise && !first_edge;
            end else begin
                capture = rise;
                change  = fall && !last_edge;
            end
        end
    end

    // Shift registers and serial output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shreg <= '0;
            rx_word  <= '0;
            mosi     <= 1'b0;
            lsb_q    <= 1'b0;
        end else if (load) begin
            tx_shreg <= tx_data;
            rx_word  <= '0;
            lsb_q    <= lsb_first;
            mosi     <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        end else begin
            if (change) begin
                if (lsb_q) begin
                    tx_shreg <= {1'b0, tx_shreg[DATA_W-1:1]};
                    mosi     <= tx_shreg[1];
                end else begin
                    tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
                    mosi     <= tx_shreg[DATA_W-2];
                end
            end
            if (capture) begin
                if (lsb_q) begin
                    rx_word <= {miso, rx_word[DATA_W-1:1]};
                end else begin
                    rx_word <= {rx_word[DATA_W-2:0], miso};
                end
            end
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transaction sequencer sitting in front of the baud-rate generator.
// Accepts a word request, latches mode/selector for the generator, gates its
// strobe and SCLK enables, owns slave select and returns the received word.
// Optional feature macro: SPI_XFER_LSB_FIRST_EN adds input lsb_first.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, tx_data             request and word to send (sampled in IDLE)
//   cfg_mode, cfg_sel          mode {cpol,cpha} and baud selector (latched)
//   busy, done, rx_data        status, one-cycle done pulse, received word
//   brg_en, brg_sclk_en        generator strobe / SCLK toggle enables
//   brg_mode, brg_sel          latched configuration to the generator
//   brg_strobe/rise/fall       generator strobe and edge pulses
//   ss_n, mosi, miso           SPI pins
//   lsb_first                  (feature only) LSB-first bit order
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned SETUP_STROBES = SETUP_STROBES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        cfg_mode,
    input  logic [2:0]        cfg_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              brg_en,
    output logic              brg_sclk_en,
    output logic [1:0]        brg_mode,
    output logic [2:0]        brg_sel,
    input  logic              brg_strobe,
    input  logic              brg_rise,
    input  logic              brg_fall,
    output logic              ss_n,
    output logic              mosi,
`ifdef SPI_XFER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam int unsigned STB_W  = 4;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(SETUP_STROBES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [STB_W-1:0]  stb_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              busy_d;
    logic              ss_n_d;
    logic              brg_en_d;
    logic              sclk_en_d;
    logic              done_d;
    logic              accept;
    logic              rx_load;
    logic              lsb_req;
    logic [DATA_W-1:0] rx_word;

`ifdef SPI_XFER_LSB_FIRST_EN
    assign lsb_req = lsb_first;
`else
    assign lsb_req = 1'b0;
`endif

    assign accept  = (state == ST_IDLE) && start;
    assign rx_load = (state == ST_HOLD) && (state_nxt == ST_DONE);

    // State register plus registered FSM outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            ss_n        <= 1'b1;
            brg_en      <= 1'b0;
            brg_sclk_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= busy_d;
            ss_n        <= ss_n_d;
            brg_en      <= brg_en_d;
            brg_sclk_en <= sclk_en_d;
            done        <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SETUP;
            ST_SETUP: if (brg_strobe && stb_cnt == STB_LAST) state_nxt = ST_XFER;
            ST_XFER:  if (brg_strobe && edge_cnt == EDGE_LAST) state_nxt = ST_HOLD;
            ST_HOLD:  if (brg_strobe && stb_cnt == STB_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registers line up with it
    always_comb begin
        busy_d    = 1'b0;
        ss_n_d    = 1'b1;
        brg_en_d  = 1'b0;
        sclk_en_d = 1'b0;
        done_d    = 1'b0;
        case (state_nxt)
            ST_SETUP, ST_HOLD: begin
                busy_d   = 1'b1;
                ss_n_d   = 1'b0;
                brg_en_d = 1'b1;
            end
            ST_XFER: begin
                busy_d    = 1'b1;
                ss_n_d    = 1'b0;
                brg_en_d  = 1'b1;
                sclk_en_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Strobe/edge counters, latched configuration and received word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_cnt  <= '0;
            edge_cnt <= '0;
            brg_mode <= 2'b00;
            brg_sel  <= 3'b000;
            rx_data  <= '0;
        end else begin
            if (accept) begin
                brg_mode <= cfg_mode;
                brg_sel  <= cfg_sel;
            end
            if (rx_load) begin
                rx_data <= rx_word;
            end
            case (state)
                ST_SETUP, ST_HOLD: begin
                    if (brg_strobe) begin
                        stb_cnt <= (stb_cnt == STB_LAST) ? '0 : stb_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (brg_strobe) begin
                        edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + 1'b1;
                    end
                end
                default: begin
                    stb_cnt  <= '0;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    spi_shift_unit #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .tx_data    (tx_data),
        .lsb_first  (lsb_req),
        .cpha       (brg_mode[CPHA]),
        .active     (state == ST_XFER),
        .first_edge (edge_cnt == '0),
        .last_edge  (edge_cnt == EDGE_LAST),
        .rise       (brg_rise),
        .fall       (brg_fall),
        .miso       (miso),
        .mosi       (mosi),
        .rx_word    (rx_word)
    );

endmodule
